usb_protocol_fsm: RTL

- Transaction-layer engine between the read/write sequencer (upstream) and the packet encoder/decoder (downstream).
- Accepts one message code per transaction: OUT token, IN token, OUT data or IN data.
- Issues the matching packet(s) to the encoder and collects handshake/data packets from the decoder.
- Runs per-transaction timeout and retry logic, then reports completion (protocol_free) or failure (timeout) upstream.

---
 rtl/usb_protocol_fsm.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_protocol_fsm.sv
// USB transaction-layer engine: turns one upstream message code into token/data/handshake
// packets, tracks device responses with a saturating timer and bounded retries.
module usb_protocol_fsm #(
    parameter logic [6:0] ADDR        = 7'd5,
    parameter logic [3:0] ENDP_OUT    = 4'd4,
    parameter logic [3:0] ENDP_IN     = 4'd8,
    parameter logic [7:0] TIMEOUT_CYC = 8'd255,
    parameter logic [3:0] MAX_RETRY   = 4'd8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [2:0]  msg_type,
    input  logic [63:0] rw_dout,
    output logic        protocol_free,
    output logic        timeout,
    output logic [63:0] rw_din,
    output logic        pkt_send,
    output logic [1:0]  pkt_kind,
    output logic [3:0]  pkt_pid,
    output logic [6:0]  pkt_addr,
    output logic [3:0]  pkt_endp,
    output logic [63:0] pkt_data,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic        rx_err,
    input  logic [63:0] rx_data
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic [1:0] KIND_TOK  = 2'b00;
    localparam logic [1:0] KIND_DATA = 2'b01;
    localparam logic [1:0] KIND_HS   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_TOK,
        S_TX_DATA,
        S_WAIT_HS,
        S_WAIT_DATA,
        S_TX_HS
    } state_t;

    state_t      r_state;
    logic [7:0]  r_timer;
    logic [3:0]  r_retry;
    logic [63:0] r_hold;

    state_t      w_state_nx;
    logic [7:0]  w_timer_nx;
    logic [3:0]  w_retry_nx;
    logic [63:0] w_hold_nx;
    logic [63:0] w_din_nx;
    logic        w_send_nx;
    logic        w_timeout_nx;
    logic [1:0]  w_kind_nx;
    logic [3:0]  w_pid_nx;
    logic [6:0]  w_addr_nx;
    logic [3:0]  w_endp_nx;
    logic [63:0] w_data_nx;
    logic        w_fail;
    logic [7:0]  w_timer_inc;
    logic [3:0]  w_retry_inc;
    logic        w_expired;

    assign protocol_free = (r_state == S_IDLE);
    assign w_timer_inc   = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;
    assign w_retry_inc   = r_retry + 4'd1;
    assign w_expired     = (r_timer == TIMEOUT_CYC);

    always_comb begin
        w_state_nx   = r_state;
        w_timer_nx   = r_timer;
        w_retry_nx   = r_retry;
        w_hold_nx    = r_hold;
        w_din_nx     = rw_din;
        w_send_nx    = 1'b0;
        w_timeout_nx = 1'b0;
        w_kind_nx    = pkt_kind;
        w_pid_nx     = pkt_pid;
        w_addr_nx    = pkt_addr;
        w_endp_nx    = pkt_endp;
        w_data_nx    = pkt_data;
        w_fail       = 1'b0;

        case (r_state)
            S_IDLE: begin
                case (msg_type)
                    3'b001, 3'b010: begin
                        w_kind_nx  = KIND_TOK;
                        w_pid_nx   = (msg_type == 3'b001) ? PID_IN : PID_OUT;
                        w_endp_nx  = (msg_type == 3'b001) ? ENDP_IN : ENDP_OUT;
                        w_addr_nx  = ADDR;
                        w_send_nx  = 1'b1;
                        w_state_nx = S_TX_TOK;
                    end
                    3'b011: begin
                        w_kind_nx  = KIND_DATA;
                        w_pid_nx   = PID_DATA0;
                        w_data_nx  = rw_dout;
                        w_retry_nx = '0;
                        w_send_nx  = 1'b1;
                        w_state_nx = S_TX_DATA;
                    end
                    3'b100: begin
                        w_retry_nx = '0;
                        w_timer_nx = '0;
                        w_state_nx = S_WAIT_DATA;
                    end
                    default: ;
                endcase
            end
            S_TX_TOK: begin
                if (tx_done) w_state_nx = S_IDLE;
            end
            S_TX_DATA: begin
                if (tx_done) begin
                    w_timer_nx = '0;
                    w_state_nx = S_WAIT_HS;
                end
            end
            S_WAIT_HS: begin
                w_timer_nx = w_timer_inc;
                // A received packet takes priority over a timer expiring on the same cycle
                if (rx_valid) begin
                    if (!rx_err && rx_pid == PID_ACK) w_state_nx = S_IDLE;
                    else                               w_fail     = 1'b1;
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
                if (w_fail) begin
                    w_retry_nx = w_retry_inc;
                    if (w_retry_inc == MAX_RETRY) begin
                        w_state_nx   = S_IDLE;
                        w_timeout_nx = 1'b1;
                    end else begin
                        w_kind_nx  = KIND_DATA;
                        w_pid_nx   = PID_DATA0;
                        w_send_nx  = 1'b1;
                        w_state_nx = S_TX_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                w_timer_nx = w_timer_inc;
                if (rx_valid || w_expired) begin
                    w_kind_nx  = KIND_HS;
                    w_send_nx  = 1'b1;
                    w_state_nx = S_TX_HS;
                    if (rx_valid && !rx_err && rx_pid == PID_DATA0) begin
                        w_hold_nx = rx_data;
                        w_pid_nx  = PID_ACK;
                    end else begin
                        w_pid_nx  = PID_NAK;
                    end
                end
            end
            S_TX_HS: begin
                if (tx_done) begin
                    if (pkt_pid == PID_ACK) begin
                        w_din_nx   = r_hold;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_retry_nx = w_retry_inc;
                        if (w_retry_inc == MAX_RETRY) begin
                            w_state_nx   = S_IDLE;
                            w_timeout_nx = 1'b1;
                        end else begin
                            w_timer_nx = '0;
                            w_state_nx = S_WAIT_DATA;
                        end
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_retry  <= '0;
            r_hold   <= '0;
            rw_din   <= '0;
            timeout  <= 1'b0;
            pkt_send <= 1'b0;
            pkt_kind <= '0;
            pkt_pid  <= '0;
            pkt_addr <= '0;
            pkt_endp <= '0;
            pkt_data <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_timer  <= w_timer_nx;
            r_retry  <= w_retry_nx;
            r_hold   <= w_hold_nx;
            rw_din   <= w_din_nx;
            timeout  <= w_timeout_nx;
            pkt_send <= w_send_nx;
            pkt_kind <= w_kind_nx;
            pkt_pid  <= w_pid_nx;
            pkt_addr <= w_addr_nx;
            pkt_endp <= w_endp_nx;
            pkt_data <= w_data_nx;
        end
    end

endmodule
